// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 32x32 register file.
// Two writeback requesters (ALU and memory load) share one write port.
// A clear sequencer writes CLEAR_VALUE to registers 1..2**ADDR_W-1.
// All register-file outputs are registered, giving one cycle of latency
// from a transfer to the write strobe.
module regfile_write_arbiter #(
    parameter int                ADDR_W      = 5,
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req0_Valid,
    input  logic [ADDR_W-1:0] Req0_Addr,
    input  logic [DATA_W-1:0] Req0_Data,
    output logic              Req0_Ready,
    input  logic              Req1_Valid,
    input  logic [ADDR_W-1:0] Req1_Addr,
    input  logic [DATA_W-1:0] Req1_Data,
    output logic              Req1_Ready,
    input  logic              Clear_Start,
    output logic              Clear_Busy,
    output logic              Write_Reg,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [DATA_W-1:0] W_Data
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] next_count;
    logic              last_grant;
    logic              next_last_grant;
    logic              grant0;
    logic              grant1;
    logic              write_next;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] data_next;

    // Next-state, arbitration and write-port selection for the coming cycle.
    always_comb begin
        next_state      = state;
        next_count      = count;
        next_last_grant = last_grant;
        grant0          = 1'b0;
        grant1          = 1'b0;
        write_next      = 1'b0;
        addr_next       = W_Addr;
        data_next       = W_Data;

        case (state)
            IDLE: begin
                if (Clear_Start) begin
                    // A clear command takes priority; no requester is served.
                    next_state = CLEAR;
                    next_count = ADDR_W'(1);
                end else if (Req0_Valid && (!Req1_Valid || last_grant)) begin
                    // Requester 0 is granted when it is alone or when
                    // requester 1 held the last grant.
                    grant0          = 1'b1;
                    next_last_grant = 1'b0;
                    if (Req0_Addr != '0) begin
                        write_next = 1'b1;
                        addr_next  = Req0_Addr;
                        data_next  = Req0_Data;
                    end
                end else if (Req1_Valid) begin
                    grant1          = 1'b1;
                    next_last_grant = 1'b1;
                    if (Req1_Addr != '0) begin
                        write_next = 1'b1;
                        addr_next  = Req1_Addr;
                        data_next  = Req1_Data;
                    end
                end
            end
            CLEAR: begin
                write_next = 1'b1;
                addr_next  = count;
                data_next  = CLEAR_VALUE;
                if (count == '1) begin
                    // The last register is being written, so return to IDLE
                    // and do not wrap the counter.
                    next_state = IDLE;
                    next_count = '0;
                end else begin
                    next_count = count + ADDR_W'(1);
                end
            end
            default: begin
                next_state = IDLE;
                next_count = '0;
            end
        endcase
    end

    assign Req0_Ready = grant0;
    assign Req1_Ready = grant1;

    // State, counter, round-robin pointer and registered write port.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            count      <= '0;
            last_grant <= 1'b1;
            Clear_Busy <= 1'b0;
            Write_Reg  <= 1'b0;
            W_Addr     <= '0;
            W_Data     <= '0;
        end else begin
            state      <= next_state;
            count      <= next_count;
            last_grant <= next_last_grant;
            Clear_Busy <= (next_state == CLEAR);
            Write_Reg  <= write_next;
            W_Addr     <= addr_next;
            W_Data     <= data_next;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;

    logic        Clk;
    logic        Reset;
    logic        Req0_Valid;
    logic [4:0]  Req0_Addr;
    logic [31:0] Req0_Data;
    logic        Req0_Ready;
    logic        Req1_Valid;
    logic [4:0]  Req1_Addr;
    logic [31:0] Req1_Data;
    logic        Req1_Ready;
    logic        Clear_Start;
    logic        Clear_Busy;
    logic        Write_Reg;
    logic [4:0]  W_Addr;
    logic [31:0] W_Data;

    int vectorCount = 0;
    int missCount   = 0;

    regfile_write_arbiter #(
        .ADDR_W     (5),
        .DATA_W     (32),
        .CLEAR_VALUE(32'h0000_0000)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Req0_Valid (Req0_Valid),
        .Req0_Addr  (Req0_Addr),
        .Req0_Data  (Req0_Data),
        .Req0_Ready (Req0_Ready),
        .Req1_Valid (Req1_Valid),
        .Req1_Addr  (Req1_Addr),
        .Req1_Data  (Req1_Data),
        .Req1_Ready (Req1_Ready),
        .Clear_Start(Clear_Start),
        .Clear_Busy (Clear_Busy),
        .Write_Reg  (Write_Reg),
        .W_Addr     (W_Addr),
        .W_Data     (W_Data)
    );

    // Free-running 10-unit clock.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Counts one comparison and reports it when the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drives all requester inputs and lets the combinational Ready settle.
    task automatic applyStimulus(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                                 input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                                 input logic clr);
        Req0_Valid  = v0;
        Req0_Addr   = a0;
        Req0_Data   = d0;
        Req1_Valid  = v1;
        Req1_Addr   = a1;
        Req1_Data   = d1;
        Clear_Start = clr;
        #1;
    endtask

    // Advances to just after the next rising edge.
    task automatic stepClock();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b0;
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
        stepClock();
        stepClock();
        checkOutput("reset_write", 32'(Write_Reg), 32'd0);
        checkOutput("reset_busy", 32'(Clear_Busy), 32'd0);
        Reset = 1'b1;
        stepClock();

        // Idle after reset.
        checkOutput("idle_write", 32'(Write_Reg), 32'd0);
        checkOutput("idle_addr", 32'(W_Addr), 32'd0);
        checkOutput("idle_data", W_Data, 32'h0);
        checkOutput("idle_busy", 32'(Clear_Busy), 32'd0);
        checkOutput("idle_rdy0", 32'(Req0_Ready), 32'd0);
        checkOutput("idle_rdy1", 32'(Req1_Ready), 32'd0);

        // Single requester 0 write.
        applyStimulus(1, 5'd1, 32'h1111_1111, 0, 5'd0, 32'h0, 0);
        checkOutput("single_rdy0", 32'(Req0_Ready), 32'd1);
        checkOutput("single_rdy1", 32'(Req1_Ready), 32'd0);
        stepClock();
        applyStimulus(0, 5'd1, 32'h1111_1111, 0, 5'd0, 32'h0, 0);
        checkOutput("single_write", 32'(Write_Reg), 32'd1);
        checkOutput("single_addr", 32'(W_Addr), 32'd1);
        checkOutput("single_data", W_Data, 32'h1111_1111);
        stepClock();
        checkOutput("single_after", 32'(Write_Reg), 32'd0);
        checkOutput("single_hold", 32'(W_Addr), 32'd1);

        // Requester 1 targeting r0: accepted but suppressed.
        applyStimulus(0, 5'd0, 32'h0, 1, 5'd0, 32'hFFFF_FFFF, 0);
        checkOutput("r0_rdy1", 32'(Req1_Ready), 32'd1);
        checkOutput("r0_rdy0", 32'(Req0_Ready), 32'd0);
        stepClock();
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
        checkOutput("r0_write", 32'(Write_Reg), 32'd0);

        // Both valid: last grant went to 1, so 0 wins first and they alternate.
        applyStimulus(1, 5'd2, 32'hAAAA_AAAA, 1, 5'd3, 32'h5555_5555, 0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("rr_rdy0_%0d", i), 32'(Req0_Ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput($sformatf("rr_rdy1_%0d", i), 32'(Req1_Ready), (i % 2 == 0) ? 32'd0 : 32'd1);
            stepClock();
            checkOutput($sformatf("rr_write_%0d", i), 32'(Write_Reg), 32'd1);
            checkOutput($sformatf("rr_addr_%0d", i), 32'(W_Addr), (i % 2 == 0) ? 32'd2 : 32'd3);
            checkOutput($sformatf("rr_data_%0d", i), W_Data,
                        (i % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555);
        end
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
        stepClock();
        checkOutput("rr_after", 32'(Write_Reg), 32'd0);

        // Clear sequence with requester 0 waiting; a second start mid-clear is ignored.
        applyStimulus(1, 5'd5, 32'h0000_1234, 0, 5'd0, 32'h0, 1);
        checkOutput("clr_start_rdy0", 32'(Req0_Ready), 32'd0);
        stepClock();
        for (int c = 1; c <= 31; c++) begin
            applyStimulus(1, 5'd5, 32'h0000_1234, 0, 5'd0, 32'h0, (c == 5) ? 1'b1 : 1'b0);
            checkOutput($sformatf("clr_rdy0_%0d", c), 32'(Req0_Ready), 32'd0);
            checkOutput($sformatf("clr_busy_%0d", c), 32'(Clear_Busy), 32'd1);
            checkOutput($sformatf("clr_write_%0d", c), 32'(Write_Reg), (c > 1) ? 32'd1 : 32'd0);
            if (c > 1) begin
                checkOutput($sformatf("clr_addr_%0d", c), 32'(W_Addr), 32'(c - 1));
                checkOutput($sformatf("clr_data_%0d", c), W_Data, 32'h0);
            end
            stepClock();
        end
        applyStimulus(1, 5'd5, 32'h0000_1234, 0, 5'd0, 32'h0, 0);
        checkOutput("clr_end_busy", 32'(Clear_Busy), 32'd0);
        checkOutput("clr_end_write", 32'(Write_Reg), 32'd1);
        checkOutput("clr_end_addr", 32'(W_Addr), 32'd31);
        checkOutput("clr_end_data", W_Data, 32'h0);
        checkOutput("clr_end_rdy0", 32'(Req0_Ready), 32'd1);
        stepClock();
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
        checkOutput("post_clr_write", 32'(Write_Reg), 32'd1);
        checkOutput("post_clr_addr", 32'(W_Addr), 32'd5);
        checkOutput("post_clr_data", W_Data, 32'h0000_1234);
        stepClock();
        checkOutput("post_clr_idle", 32'(Write_Reg), 32'd0);

        // Reset asserted mid-clear while writing register 10.
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1);
        stepClock();
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
        for (int k = 0; k < 10; k++) stepClock();
        checkOutput("mid_addr", 32'(W_Addr), 32'd10);
        checkOutput("mid_write", 32'(Write_Reg), 32'd1);
        Reset = 1'b0;
        #1;
        checkOutput("async_write", 32'(Write_Reg), 32'd0);
        checkOutput("async_addr", 32'(W_Addr), 32'd0);
        checkOutput("async_data", W_Data, 32'h0);
        checkOutput("async_busy", 32'(Clear_Busy), 32'd0);
        stepClock();
        Reset = 1'b1;
        stepClock();
        checkOutput("rel_busy", 32'(Clear_Busy), 32'd0);
        checkOutput("rel_write", 32'(Write_Reg), 32'd0);
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1);
        stepClock();
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
        checkOutput("restart_busy", 32'(Clear_Busy), 32'd1);
        stepClock();
        checkOutput("restart_write", 32'(Write_Reg), 32'd1);
        checkOutput("restart_addr", 32'(W_Addr), 32'd1);
        checkOutput("restart_data", W_Data, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
